// File: rtl/ad9680_cpack_pkg.sv
// Shared constants, pack-state encoding and the dual-channel interleave helper
// for the AD9680 channel packer.
package ad9680_cpack_pkg;

    localparam int SAMPLE_WIDTH     = 16;
    localparam int SAMPLES_PER_BEAT = 4;
    localparam int CH_WIDTH         = 64;
    localparam int PACK_WIDTH       = 128;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DUAL      = 2'd1,
        SINGLE_LO = 2'd2,
        SINGLE_HI = 2'd3
    } state_e;

    // Entry state of each mode; 01 and 10 both start by filling the low half.
    function automatic state_e entry_state(input logic [1:0] mask);
        case (mask)
            2'b00:   return IDLE;
            2'b11:   return DUAL;
            default: return SINGLE_LO;
        endcase
    endfunction

    function automatic logic [PACK_WIDTH-1:0] interleave(input logic [CH_WIDTH-1:0] c0,
                                                        input logic [CH_WIDTH-1:0] c1);
        logic [PACK_WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
            w[2*SAMPLE_WIDTH*i +: SAMPLE_WIDTH]              = c0[SAMPLE_WIDTH*i +: SAMPLE_WIDTH];
            w[2*SAMPLE_WIDTH*i+SAMPLE_WIDTH +: SAMPLE_WIDTH] = c1[SAMPLE_WIDTH*i +: SAMPLE_WIDTH];
        end
        return w;
    endfunction

endpackage

// File: rtl/ad9680_cpack_if.sv
// Packed-word output stream toward the DMA side.
// Handshake: a word transfers on a cycle where pack_valid & pack_ready; the source keeps
// pack_valid/pack_data/pack_sync stable until then. dbg_state mirrors the pack FSM.
interface ad9680_cpack_if;
    import ad9680_cpack_pkg::*;

    logic                  pack_valid;
    logic [PACK_WIDTH-1:0] pack_data;
    logic                  pack_sync;
    logic                  pack_ready;
    state_e                dbg_state;

    modport master (output pack_valid, output pack_data, output pack_sync,
                    output dbg_state, input pack_ready);
    modport slave  (input pack_valid, input pack_data, input pack_sync,
                    input dbg_state, output pack_ready);
endinterface

// File: rtl/ad9680_cpack_fifo.sv
// Synchronous FIFO whose head is presented as a registered valid/data output and
// popped on valid & ready; a push into a full FIFO is accepted only alongside a pop.
module ad9680_cpack_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 129
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_ready_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             full_o
);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr_q;
    logic [FIFO_AW:0] rd_ptr_q;
    logic             empty;
    logic             pop;
    logic             wr_en;

    // Equal indices: the extra MSB tells a full wrap from an empty FIFO.
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full_o = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                    (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop    = !empty && pop_ready_i;
    assign wr_en  = push_i && (!full_o || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q[FIFO_AW-1:0]] <= push_data_i;
    end

    assign out_valid_o = !empty;
    assign out_data_o  = empty ? '0 : mem[rd_ptr_q[FIFO_AW-1:0]];

endmodule

// File: rtl/ad9680_cpack.sv
// AD9680 channel packer: packs enabled channel beats into 128-bit words, buffers them
// and flags drops on adc_dovf. Define AD9680_CPACK_OVF_COUNT_EN to add ovf_count.
module ad9680_cpack
    import ad9680_cpack_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                adc_clk,
    input  logic                adc_rst,
    input  logic                adc_enable_0,
    input  logic                adc_valid_0,
    input  logic [CH_WIDTH-1:0] adc_data_0,
    input  logic                adc_enable_1,
    input  logic                adc_valid_1,
    input  logic [CH_WIDTH-1:0] adc_data_1,
    output logic                adc_dovf,
`ifdef AD9680_CPACK_OVF_COUNT_EN
    output logic [15:0]         ovf_count,
`endif
    ad9680_cpack_if.master      pack
);
    logic [1:0]            mask;
    logic [1:0]            mask_q;
    logic                  mask_chg;
    state_e                state_q;
    state_e                cur_state;
    logic [CH_WIDTH-1:0]   hold_q;
    logic                  single_valid;
    logic [CH_WIDTH-1:0]   single_data;
    logic                  word_fire;
    logic [PACK_WIDTH-1:0] word_next;
    logic                  word_sync;
    logic                  word_vld_q;
    logic [PACK_WIDTH-1:0] word_q;
    logic                  word_sync_q;
    logic                  sync_pend_q;
    logic                  dovf_q;
    logic                  fifo_full;
    logic                  drop;
    logic [PACK_WIDTH:0]   fifo_out;

    assign mask     = {adc_enable_1, adc_enable_0};
    assign mask_chg = (mask != mask_q);
    // A beat arriving with a mask change is handled in the new mode straight away.
    assign cur_state = mask_chg ? entry_state(mask) : state_q;

    assign single_valid = adc_enable_0 ? adc_valid_0 : adc_valid_1;
    assign single_data  = adc_enable_0 ? adc_data_0  : adc_data_1;

    assign word_fire = ((cur_state == DUAL) && adc_valid_0 && adc_valid_1) ||
                       ((cur_state == SINGLE_HI) && single_valid);
    assign word_next = (cur_state == DUAL) ? interleave(adc_data_0, adc_data_1)
                                           : {single_data, hold_q};

    assign drop      = word_vld_q && fifo_full && !(pack.pack_valid && pack.pack_ready);
    assign word_sync = sync_pend_q || mask_chg || drop;

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            mask_q      <= '0;
            state_q     <= IDLE;
            hold_q      <= '0;
            word_vld_q  <= 1'b0;
            word_q      <= '0;
            word_sync_q <= 1'b0;
            sync_pend_q <= 1'b1;
            dovf_q      <= 1'b0;
        end else begin
            mask_q     <= mask;
            word_vld_q <= word_fire;
            dovf_q     <= drop;
            state_q    <= cur_state;
            if (mask_chg) hold_q <= '0;
            if (word_fire) begin
                word_q      <= word_next;
                word_sync_q <= word_sync;
                sync_pend_q <= 1'b0;
            end else begin
                sync_pend_q <= word_sync;
            end
            case (cur_state)
                SINGLE_LO: if (single_valid) begin
                    hold_q  <= single_data;
                    state_q <= SINGLE_HI;
                end
                SINGLE_HI: if (single_valid) state_q <= SINGLE_LO;
                default: ;
            endcase
        end
    end

    ad9680_cpack_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (PACK_WIDTH + 1)
    ) u_fifo (
        .clk         (adc_clk),
        .rst         (adc_rst),
        .push_i      (word_vld_q),
        .push_data_i ({word_sync_q, word_q}),
        .pop_ready_i (pack.pack_ready),
        .out_valid_o (pack.pack_valid),
        .out_data_o  (fifo_out),
        .full_o      (fifo_full)
    );

    assign pack.pack_sync = fifo_out[PACK_WIDTH];
    assign pack.pack_data = fifo_out[PACK_WIDTH-1:0];
    assign pack.dbg_state = state_q;
    assign adc_dovf       = dovf_q;

`ifdef AD9680_CPACK_OVF_COUNT_EN
    logic [15:0] ovf_cnt_q;

    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst)                            ovf_cnt_q <= '0;
        else if (drop && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end

    assign ovf_count = ovf_cnt_q;
`endif

endmodule

// File: doc/ad9680_cpack.md
Name: ad9680_cpack

Overview:
- Downstream stage of the AD9680 JESD204 ADC core.
- Consumes the two 64-bit per-channel sample buses: 4 samples × 16-bit each, 14-bit data sign-extended.
- Packs enabled channels into dense 128-bit words and buffers them in a small FIFO.
- Drives a valid/ready stream toward the DMA write side; reports overflow back to the core on adc_dovf.

Parameters:
- FIFO_DEPTH, 16, number of 128-bit words buffered; power of two, minimum 4.
- FIFO_AW, $clog2(FIFO_DEPTH), FIFO address width; derived, not overridden.

Ports:
- adc_clk  input  1  sample clock; everything is synchronous to it.
- adc_rst  input  1  asynchronous, active-high reset.
- adc_enable_0  input  1  channel 0 enabled.
- adc_valid_0  input  1  channel 0 beat valid.
- adc_data_0  input  64  channel 0 samples; sample i at [16i+15:16i].
- adc_enable_1  input  1  channel 1 enabled.
- adc_valid_1  input  1  channel 1 beat valid.
- adc_data_1  input  64  channel 1 samples.
- adc_dovf  output  1  overflow; one-cycle pulse per dropped word.
- pack_valid  output  1  output word valid.
- pack_data  output  128  packed output word.
- pack_sync  output  1  high with the first word after any enable-mask change.
- pack_ready  input  1  downstream accepts the word.

Behaviour:
- Reset (async, adc_rst=1):
  - pack_valid=0, pack_data=0, pack_sync=0, adc_dovf=0.
  - FIFO empty; state IDLE; held half cleared.
- Mode is taken from mask {adc_enable_1, adc_enable_0}, registered each cycle.
- State machine:
  - IDLE (mask 00): no input is consumed.
  - DUAL (mask 11): beat = adc_valid_0 & adc_valid_1. Word = interleaved samples: bits [32i+15:32i] = ch0 sample i, bits [32i+31:32i+16] = ch1 sample i, for i=0..3. One word per beat.
  - SINGLE_LO (mask 01 or 10): beat = valid of the enabled channel. Its 64 bits are held as the low half; go to SINGLE_HI.
  - SINGLE_HI: next beat fills bits [127:64]; emit the word; return to SINGLE_LO.
- Mask change (any value differs from the previous cycle):
  - Held half is discarded.
  - State goes to the entry state of the new mode.
  - sync_pending is set; the first word pushed afterwards carries sync=1, then sync_pending clears.
  - A beat in the same cycle as the change uses the new mask.
- Latency:
  - Beat at cycle N completes a word → word is registered at N+1 and pushed into the FIFO.
  - If the FIFO was empty, pack_valid rises at N+2.
- FIFO:
  - Stores {sync, data}; width 129.
  - Output register: pack_valid/pack_data/pack_sync are held stable while pack_valid=1 and pack_ready=0.
  - Transfer occurs when pack_valid & pack_ready.
  - Simultaneous push and pop when full: push is accepted, no overflow.
  - Full, push with no pop: word dropped; adc_dovf=1 for the following cycle; sync_pending is re-set so the next stored word is marked sync.
  - Empty: pack_valid=0; pack_ready is ignored.
- Pointers are FIFO_AW+1 bits wide with wrap-around; full and empty are distinguished by the MSB.
- Reset mid-operation: all content is lost immediately, with no flush.

Optional Feature:
- Macro: AD9680_CPACK_OVF_COUNT_EN.
- Defined: adds output port ovf_count (16 bits).
  - Increments once per dropped word and saturates at 16'hFFFF.
  - Cleared only by adc_rst.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ad9680_cpack_pkg holds:
  - SAMPLE_WIDTH=16, SAMPLES_PER_BEAT=4, CH_WIDTH=64, PACK_WIDTH=128.
  - State enum {IDLE, DUAL, SINGLE_LO, SINGLE_HI}.
- One sub-module, ad9680_cpack_fifo: synchronous FIFO with registered output and valid/ready pop, parameterised by FIFO_DEPTH and width.
- Pack state machine and overflow logic live in the top.

Test Plan:
- Both channels enabled, pack_ready=1; ch0=64'h0003_0002_0001_0000, ch1=64'h0013_0012_0011_0010 → pack_data=128'h0013_0003_0012_0002_0011_0001_0010_0000, pack_sync=1, pack_valid at N+2.
- Only ch1 enabled; beats A=64'hAAAA…, B=64'hBBBB… → one word {B,A}. A third lone beat produces no output until a fourth beat arrives.
- Single mode with one half held, then switch mask to 11 → held half is discarded; next dual word has pack_sync=1; no mixed word appears.
- pack_ready=0, DUAL beats every cycle, FIFO_DEPTH=16:
  - words 1–16 stored;
  - word 17 dropped, adc_dovf pulses one cycle;
  - with the feature on, ovf_count=1;
  - after draining, the first stored post-drop word has pack_sync=1.
- FIFO full with pack_ready=1 and a beat in the same cycle → no overflow; occupancy unchanged; output order preserved.
- Assert adc_rst with FIFO half full → outputs go to 0 immediately (no clock edge needed); after release, the first word has pack_sync=1.
